// File: rtl/ste_bar_level_gen.sv
// Display level generator for the LED bar: per-window maximum with instant attack,
// limited decay, one-cycle update strobe and a peak-hold marker value.
module ste_bar_level_gen #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned REFRESH_CYC = 1_000_000,
  parameter int unsigned DECAY_STEP  = 1,
  parameter int unsigned HOLD_WIN    = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] level_o,
  output logic              level_update_o,
  output logic [DATA_W-1:0] peak_o
);

  localparam int unsigned CNT_W  = $clog2(REFRESH_CYC);
  localparam int unsigned HOLD_W = $clog2(HOLD_WIN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(REFRESH_CYC - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_WIN - 1);

  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0] win_max_q, win_max_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              update_q, update_d;

  logic              tick;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] decayed;
  logic [DATA_W-1:0] lvl_n;

  always_comb begin
    tick = (win_cnt_q == LAST_CNT);

    // A sample in the tick cycle still belongs to the closing window.
    m = win_max_q;
    if (sample_valid_i && (sample_i > win_max_q)) begin
      m = sample_i;
    end

    // Saturating decay; compared wide so any DECAY_STEP value floors at zero.
    decayed = '0;
    if (32'(level_q) > DECAY_STEP) begin
      decayed = level_q - DATA_W'(DECAY_STEP);
    end

    if (m >= level_q) begin
      lvl_n = m;
    end else if (m > decayed) begin
      lvl_n = m;
    end else begin
      lvl_n = decayed;
    end

    win_cnt_d  = tick ? '0 : win_cnt_q + 1'b1;
    win_max_d  = tick ? '0 : m;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    peak_d     = peak_q;
    update_d   = 1'b0;

    if (tick) begin
      level_d  = lvl_n;
      update_d = 1'b1;
      if ((lvl_n >= peak_q) || (hold_cnt_q == LAST_HOLD)) begin
        peak_d     = lvl_n;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    if (clr_i) begin
      win_cnt_d  = '0;
      win_max_d  = '0;
      hold_cnt_d = '0;
      level_d    = '0;
      peak_d     = '0;
      update_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      win_max_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= '0;
      peak_q     <= '0;
      update_q   <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_max_q  <= win_max_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      update_q   <= update_d;
    end
  end

  assign level_o        = level_q;
  assign level_update_o = update_q;
  assign peak_o         = peak_q;

endmodule
